// File: rtl/adc_read_manager.sv
// -----------------------------------------------------------------------------
// adc_read_manager
//   Timing/control generator for an external parallel ADC with
//   CONVST/BUSY/CS/RD handshake. A programmable-rate tick starts each
//   conversion. The FSM pulses CONVST, waits for BUSY to rise and then fall,
//   strobes CS/RD together and captures DB. The captured sample is presented
//   with a one-cycle sampleValid pulse.
//
//   Optional feature macro: ADC_TIMEOUT_EN
//     defined   : a BUSY wait longer than TIMEOUT_CYC cycles aborts the
//                 conversion and pulses timeoutErr
//     undefined : the wait states wait indefinitely; timeoutErr stays 0
//
// Ports
//   Clk         system clock, rising edge
//   adcRst      asynchronous active-low reset
//   adcEn       enable new conversions
//   adcFr       rate select, sample period = 32 << adcFr cycles
//   BUSY        ADC busy (asynchronous, synchronized internally)
//   DB          ADC parallel data
//   CONVST      convert start, active low
//   CS, RD      chip select / read strobe, active low, always switch together
//   sample      last captured sample
//   sampleValid one-cycle pulse when sample updates
//   overrun     sticky: a tick arrived while a conversion was in progress
//   timeoutErr  one-cycle pulse when a BUSY wait is aborted
// -----------------------------------------------------------------------------
module adc_read_manager #(
    parameter int DATA_W      = 8,
    parameter int CONV_W      = 2,
    parameter int RD_W        = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              Clk,
    input  logic              adcRst,
    input  logic              adcEn,
    input  logic [2:0]        adcFr,
    input  logic              BUSY,
    input  logic [DATA_W-1:0] DB,
    output logic              CONVST,
    output logic              CS,
    output logic              RD,
    output logic [DATA_W-1:0] sample,
    output logic              sampleValid,
    output logic              overrun,
    output logic              timeoutErr
);

    localparam int PH_MAX = (CONV_W > RD_W) ? CONV_W : RD_W;
    localparam int PW     = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_HI,
        WAIT_LO,
        READ,
        DONE
    } state_t;

    state_t            state;
    logic [PW-1:0]     phCnt;
    logic [DATA_W-1:0] capReg;

    // ---------------------------------------------------------------
    // Rate generator. The rate select is only reloaded at wrap so a
    // change never produces a truncated period.
    // ---------------------------------------------------------------
    logic [12:0] rateCnt;
    logic [12:0] rateLast;
    logic [2:0]  frReg;
    logic        tick;

    assign rateLast = (13'd32 << frReg) - 13'd1;
    assign tick     = (rateCnt == rateLast);

    always_ff @(posedge Clk or negedge adcRst) begin
        if (!adcRst) begin
            rateCnt <= '0;
            frReg   <= '0;
        end else if (tick) begin
            rateCnt <= '0;
            frReg   <= adcFr;
        end else begin
            rateCnt <= rateCnt + 13'd1;
        end
    end

    // ---------------------------------------------------------------
    // BUSY is asynchronous to Clk: two-flop synchronizer.
    // ---------------------------------------------------------------
    logic busyMeta, busyS;

    always_ff @(posedge Clk or negedge adcRst) begin
        if (!adcRst) begin
            busyMeta <= 1'b0;
            busyS    <= 1'b0;
        end else begin
            busyMeta <= BUSY;
            busyS    <= busyMeta;
        end
    end

    // ---------------------------------------------------------------
    // BUSY wait watchdog. The counter sits at zero outside the wait
    // states, so it is automatically cleared on entry to WAIT_HI.
    // ---------------------------------------------------------------
    logic toHit;

`ifdef ADC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] toCnt;

    always_ff @(posedge Clk or negedge adcRst) begin
        if (!adcRst)
            toCnt <= '0;
        else if (state == WAIT_HI || state == WAIT_LO)
            toCnt <= toCnt + TW'(1);
        else
            toCnt <= '0;
    end

    assign toHit = (toCnt == TW'(TIMEOUT_CYC - 1));
`else
    assign toHit = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Conversion FSM with registered strobes.
    // ---------------------------------------------------------------
    always_ff @(posedge Clk or negedge adcRst) begin
        if (!adcRst) begin
            state       <= IDLE;
            phCnt       <= '0;
            CONVST      <= 1'b1;
            CS          <= 1'b1;
            RD          <= 1'b1;
            capReg      <= '0;
            sample      <= '0;
            sampleValid <= 1'b0;
            overrun     <= 1'b0;
            timeoutErr  <= 1'b0;
        end else begin
            sampleValid <= 1'b0;
            timeoutErr  <= 1'b0;

            // Disabling also acknowledges a pending overrun.
            if (!adcEn)
                overrun <= 1'b0;
            else if (tick && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (tick && adcEn) begin
                        state  <= CONV;
                        CONVST <= 1'b0;
                        phCnt  <= '0;
                    end
                end
                CONV: begin
                    if (phCnt == PW'(CONV_W - 1)) begin
                        state  <= WAIT_HI;
                        CONVST <= 1'b1;
                        phCnt  <= '0;
                    end else begin
                        phCnt <= phCnt + PW'(1);
                    end
                end
                WAIT_HI: begin
                    if (toHit) begin
                        state      <= IDLE;
                        timeoutErr <= 1'b1;
                    end else if (busyS) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // A BUSY fall in the final watchdog cycle still wins.
                    if (!busyS) begin
                        state <= READ;
                        CS    <= 1'b0;
                        RD    <= 1'b0;
                        phCnt <= '0;
                    end else if (toHit) begin
                        state      <= IDLE;
                        timeoutErr <= 1'b1;
                    end
                end
                READ: begin
                    if (phCnt == PW'(RD_W - 1)) begin
                        capReg <= DB;
                        CS     <= 1'b1;
                        RD     <= 1'b1;
                        state  <= DONE;
                    end else begin
                        phCnt <= phCnt + PW'(1);
                    end
                end
                DONE: begin
                    sample      <= capReg;
                    sampleValid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adc_read_manager.md
Name: adc_read_manager

Overview:
- Timing and control generator for an external 8-bit parallel ADC with CONVST/BUSY/CS/RD pins.
- Read-side counterpart of the DAC write-timing block: a programmable-rate tick starts each conversion; the FSM waits out BUSY, strobes CS/RD, and captures DB.
- The captured sample goes to downstream logic with a 1-cycle valid pulse.

Parameters:
DATA_W, 8, ADC data bus width
CONV_W, 2, CONVST low pulse width in Clk cycles (>=1)
RD_W, 3, CS/RD low width in Clk cycles (>=2)
TIMEOUT_CYC, 1024, max cycles in WAIT before abort (used only with ADC_TIMEOUT_EN)

Ports:
Clk  in  1  system clock, all logic on rising edge
adcRst  in  1  asynchronous active-low reset
adcEn  in  1  enable sampling; low = no new conversions
adcFr  in  3  rate select; sample period P = 32 << adcFr cycles (32..4096)
BUSY  in  1  ADC busy, active high, asynchronous to Clk
DB  in  DATA_W  ADC parallel data
CONVST  out  1  convert start, active low
CS  out  1  chip select, active low
RD  out  1  read strobe, active low
sample  out  DATA_W  last captured sample
sampleValid  out  1  1-cycle pulse when sample updates
overrun  out  1  sticky: tick arrived while FSM busy
timeoutErr  out  1  1-cycle pulse on BUSY timeout

Behaviour:
- Reset (async, adcRst=0): CONVST=1, CS=1, RD=1, sample=0, sampleValid=0, overrun=0, timeoutErr=0; rate counter=0; FSM=IDLE; BUSY synchronizer flops=0. Applies immediately mid-operation; any in-flight conversion is abandoned.
- Rate counter: 13-bit; counts 0..P-1 and wraps; tick=1 in the cycle counter==P-1. adcFr is sampled only at wrap, so a change takes effect on the next period without a short/glitched period. Counter runs regardless of adcEn.
- BUSY passes through a 2-flop synchronizer (busy_s); FSM uses only busy_s.
- FSM states:
  - IDLE: all strobes high. On tick && adcEn -> CONV.
  - CONV: CONVST=0 for exactly CONV_W cycles -> WAIT_HI.
  - WAIT_HI: wait for busy_s=1 -> WAIT_LO.
  - WAIT_LO: wait for busy_s=0 -> READ.
  - READ: CS=0 and RD=0 for exactly RD_W cycles; DB registered on the last READ cycle -> DONE.
  - DONE: CS=RD=1; sample<=captured value; sampleValid=1 this cycle only -> IDLE.
- CS and RD fall and rise on the same edges; CONVST is never low while CS/RD are low.
- Tick while FSM != IDLE: tick dropped, overrun<=1. overrun is cleared only by reset or adcEn=0. A tick coincident with the DONE cycle also counts as overrun.
- adcEn deasserted mid-conversion: current conversion completes normally (sampleValid issued); no new start.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro ADC_TIMEOUT_EN.
- Defined:
  - A cycle counter runs across WAIT_HI+WAIT_LO, reset on entry to WAIT_HI.
  - If it reaches TIMEOUT_CYC before leaving WAIT_LO: FSM -> IDLE, timeoutErr pulses 1 cycle, no READ, sample unchanged, sampleValid not asserted.
- Undefined: WAIT states wait indefinitely; timeoutErr is tied to 0 (port still present).

Test Plan:
- Basic read: adcFr=0, adcEn=1; BUSY model rises 1 cycle after CONVST falls, stays high 8 cycles; DB=8'hA5 -> CONVST low exactly 2 cycles, CS/RD low exactly 3 cycles, sample=8'hA5, sampleValid pulses every 32 cycles, overrun=0.
- Rate change: switch adcFr 0->3 mid-period -> current period still 32 cycles, then sampleValid spacing 256 cycles; DB ramp 0x00,0x01,... captured in order.
- Overrun: adcFr=0, BUSY held high 40 cycles -> overrun=1 after the first dropped tick and stays 1; drop adcEn for 1 cycle -> overrun=0.
- Enable drop mid-op: deassert adcEn during WAIT_LO -> that sample still delivered with sampleValid=1; no further CONVST pulses while adcEn=0.
- Async reset mid-READ: pull adcRst low while RD=0 -> CS=RD=CONVST=1, sample=0 without waiting for a Clk edge; after release, first CONVST occurs 32 cycles later (adcFr=0).
- Timeout (ADC_TIMEOUT_EN, TIMEOUT_CYC=64): BUSY never rises -> timeoutErr pulses once 64 cycles after entering WAIT_HI, no RD strobe, sample unchanged. Without the macro: FSM stays in WAIT_HI and timeoutErr stays 0.
